// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: one partial product per ena-qualified clock.
// Signed operands are reduced to magnitudes on accept, and the sign is reapplied
// on the final iteration. Valid/ready handshakes are used on both the operand and
// the result side.
module seq_shift_add_multiplier #(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;
  logic [CW-1:0]    count_q;
  logic             neg_q;
  logic [PW-1:0]    p_q;
  logic             out_valid_q;

  logic             accept;
  logic             sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             neg_d;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_d;

  // Operand side handshake: never depends on in_valid.
  always_comb begin
    in_ready = ena & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    accept   = in_valid & in_ready;
  end

  // Operand conditioning: magnitudes and product sign. The magnitude of the most
  // negative value wraps back to itself, which reads correctly as unsigned 2^(W-1).
  always_comb begin
    sgn   = SIGNED_EN & signed_mode;
    a_mag = (sgn & a[WIDTH-1]) ? -a : a;
    b_mag = (sgn & b[WIDTH-1]) ? -b : b;
    neg_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  // Partial product for the current multiplier bit and the next accumulator value.
  always_comb begin
    pp    = mplier_q[0] ? (PW'(mcand_q) << count_q) : '0;
    acc_d = acc_q + pp;
  end

  // Control FSM and datapath registers; every transition is qualified by ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      neg_q       <= 1'b0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            neg_q    <= neg_d;
            acc_q    <= '0;
            count_q  <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 1'b1;
          if (count_q == LAST) begin
            // Two's-complement negation of zero is zero, so no special case is needed.
            p_q         <= neg_q ? -acc_d : acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              mcand_q  <= a_mag;
              mplier_q <= b_mag;
              neg_q    <= neg_d;
              acc_q    <= '0;
              count_q  <= '0;
              state_q  <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p         = p_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier: a WIDTH=4 signed instance, plus
// WIDTH=8 instances with SIGNED_EN set to 1 and to 0 that share one stimulus stream.
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ena;

  logic [3:0]  a4, b4;
  logic        sm4, iv4, ir4, ov4, or4;
  logic [7:0]  p4;

  logic [7:0]  a8, b8;
  logic        sm8, iv8, ir8s, ir8u, ov8s, ov8u;
  logic        or8;
  logic [15:0] p8s, p8u;

  seq_shift_add_multiplier #(.WIDTH(4), .SIGNED_EN(1'b1)) u4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .a(a4), .b(b4), .signed_mode(sm4),
    .in_valid(iv4), .in_ready(ir4), .p(p4), .out_valid(ov4), .out_ready(or4));

  seq_shift_add_multiplier #(.WIDTH(8), .SIGNED_EN(1'b1)) u8s (
    .clk(clk), .rst_n(rst_n), .ena(ena), .a(a8), .b(b8), .signed_mode(sm8),
    .in_valid(iv8), .in_ready(ir8s), .p(p8s), .out_valid(ov8s), .out_ready(or8));

  seq_shift_add_multiplier #(.WIDTH(8), .SIGNED_EN(1'b0)) u8u (
    .clk(clk), .rst_n(rst_n), .ena(ena), .a(a8), .b(b8), .signed_mode(sm8),
    .in_valid(iv8), .in_ready(ir8u), .p(p8u), .out_valid(ov8u), .out_ready(or8));

  int total = 0;
  int bad   = 0;
  int edges = 0;

  typedef struct {
    logic [7:0] p;
    int         lat;
  } exp4_t;

  exp4_t       q4[$];
  int          acc4[$];
  logic        prev4 = 1'b0;
  logic [15:0] qs[$];
  logic [15:0] qu[$];

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // WIDTH=4 monitor: latency measured on the rising edge of out_valid, product on transfer.
  always @(negedge clk) begin
    exp4_t e;
    if (!rst_n) begin
      acc4.delete();
      prev4 = 1'b0;
    end else begin
      if (ov4 && !prev4) begin
        if (q4.size() == 0 || acc4.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid4: got p=%h expected no result", p4);
        end else begin
          chk("latency4", 16'(edges - acc4.pop_front()), 16'(q4[0].lat));
        end
      end
      if (ov4 && or4 && ena && q4.size() != 0) begin
        e = q4.pop_front();
        chk("product4", 16'(p4), 16'(e.p));
      end
      if (iv4 && ir4) acc4.push_back(edges + 1);
      prev4 = ov4;
    end
  end

  // WIDTH=8 monitor: output ready is tied high, so every valid cycle is a transfer.
  always @(negedge clk) begin
    if (rst_n && ena) begin
      if (ov8s) begin
        if (qs.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid8s: got p=%h expected no result", p8s);
        end else chk("product8_signed_en", p8s, qs.pop_front());
      end
      if (ov8u) begin
        if (qu.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid8u: got p=%h expected no result", p8u);
        end else chk("product8_unsigned_only", p8u, qu.pop_front());
      end
    end
  end

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                        input logic [7:0] ep, input int lat, input bit push);
    int n;
    n = 0;
    if (push) q4.push_back(exp4_t'{ep, lat});
    a4 = a; b4 = b; sm4 = sm; iv4 = 1'b1;
    forever begin
      @(negedge clk);
      if (ir4) break;
      n++;
      if (n > 60) begin
        total++; bad++;
        $display("FAIL accept4_timeout: got in_ready=0 expected 1 within 60 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    iv4 = 1'b0;
  endtask

  task automatic drain4();
    int n;
    n = 0;
    while (q4.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain4", 16'(q4.size()), 16'd0);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic [15:0] es, input logic [15:0] eu);
    int n;
    n = 0;
    qs.push_back(es);
    qu.push_back(eu);
    a8 = a; b8 = b; sm8 = sm; iv8 = 1'b1;
    forever begin
      @(negedge clk);
      if (ir8s && ir8u) break;
      n++;
      if (n > 60) begin
        total++; bad++;
        $display("FAIL accept8_timeout: got in_ready=%b%b expected 11", ir8s, ir8u);
        break;
      end
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; ena = 1'b1; or4 = 1'b1; or8 = 1'b1;
    a4 = '0; b4 = '0; sm4 = 1'b0; iv4 = 1'b0;
    a8 = '0; b8 = '0; sm8 = 1'b0; iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("reset_p4", 16'(p4), 16'h0000);
    chk("reset_out_valid4", 16'(ov4), 16'h0000);
    chk("reset_in_ready4", 16'(ir4), 16'h0001);
    chk("reset_out_valid8", 16'({ov8s, ov8u}), 16'h0000);
    @(posedge clk); #1;

    // Unsigned maximum, then back-to-back signed corners (same-edge restarts).
    issue4(4'hF, 4'hF, 1'b0, 8'hE1, 4, 1'b1);
    drain4();
    issue4(4'h8, 4'h8, 1'b1, 8'h40, 4, 1'b1);   // -8 * -8
    issue4(4'hD, 4'h5, 1'b1, 8'hF1, 4, 1'b1);   // -3 * 5
    issue4(4'h8, 4'h7, 1'b1, 8'hC8, 4, 1'b1);   // -8 * 7
    issue4(4'h0, 4'hB, 1'b1, 8'h00, 4, 1'b1);   //  0 * -5
    issue4(4'h7, 4'hF, 1'b1, 8'hF9, 4, 1'b1);   //  7 * -1
    issue4(4'hD, 4'h5, 1'b0, 8'h41, 4, 1'b1);   // 13 * 5 unsigned
    drain4();

    // Backpressure: result held 10 cycles, pending pair refused, then same-edge restart.
    or4 = 1'b0;
    issue4(4'h6, 4'h7, 1'b0, 8'd42, 4, 1'b1);
    n = 0;
    while (!ov4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 16'(ov4), 16'h0001);
    @(posedge clk); #1;
    q4.push_back(exp4_t'{8'd15, 4});
    a4 = 4'h5; b4 = 4'h3; sm4 = 1'b0; iv4 = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_p_stable", 16'(p4), 16'd42);
      chk("bp_valid_held", 16'(ov4), 16'h0001);
      chk("bp_in_ready_low", 16'(ir4), 16'h0000);
    end
    @(posedge clk); #1;
    or4 = 1'b1;
    @(negedge clk);
    chk("restart_in_ready", 16'(ir4), 16'h0001);
    @(posedge clk); #1;
    iv4 = 1'b0;
    a4 = 4'hF; b4 = 4'hF;   // changes during BUSY must not affect the product
    drain4();
    @(negedge clk);
    chk("p_hold_after_transfer", 16'(p4), 16'd15);
    chk("valid_low_after_transfer", 16'(ov4), 16'h0000);
    @(posedge clk); #1;

    // ena stall of three edges mid-operation.
    issue4(4'h9, 4'hB, 1'b0, 8'd99, 7, 1'b1);
    @(posedge clk); #1;
    ena = 1'b0;
    @(negedge clk);
    chk("stall_in_ready_low", 16'(ir4), 16'h0000);
    repeat (3) @(posedge clk);
    #1 ena = 1'b1;
    drain4();

    // Reset during the second iteration discards the in-flight product.
    issue4(4'h7, 4'h7, 1'b0, 8'h00, 0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_p4", 16'(p4), 16'h0000);
    chk("midreset_valid4", 16'(ov4), 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready4", 16'(ir4), 16'h0001);
    chk("post_reset_valid4", 16'(ov4), 16'h0000);
    chk("post_reset_p4", 16'(p4), 16'h0000);
    repeat (8) @(posedge clk);
    #1;
    issue4(4'h3, 4'h3, 1'b0, 8'd9, 4, 1'b1);
    drain4();

    // WIDTH=8: SIGNED_EN=1 honours signed_mode, SIGNED_EN=0 always multiplies unsigned.
    issue8(8'hFF, 8'hFF, 1'b1, 16'h0001, 16'hFE01);
    issue8(8'h80, 8'h80, 1'b1, 16'h4000, 16'h4000);
    issue8(8'h80, 8'h7F, 1'b1, 16'hC080, 16'h3F80);
    issue8(8'h0C, 8'hF6, 1'b1, 16'hFF88, 16'h0B88);
    issue8(8'h00, 8'h85, 1'b1, 16'h0000, 16'h0000);
    issue8(8'h64, 8'h03, 1'b1, 16'h012C, 16'h012C);
    issue8(8'hFF, 8'h02, 1'b0, 16'h01FE, 16'h01FE);
    n = 0;
    while ((qs.size() != 0 || qu.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain8", 16'(qs.size() + qu.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
